// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Hardware run sequencer for FPGA bring-up of the parametrised RISC core.
// It does in hardware what the simulation benches do for every run:
//   1. hold the core in reset,
//   2. clear data memory (every address) and the register file,
//   3. apply host-streamed preload words to data memory,
//   4. release the core and count cycles until done or timeout,
//   5. stream the final register file out over a ready/valid port.
//
// Optional feature: define RUNCTL_PC_TRACE_EN to add a PC-change trace port
// (cpu_pc_i in, trace_valid_o / trace_pc_o out). It is active only in RUN.
// With the macro undefined these ports and their logic do not exist.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   go_i                    start a run (honoured only in IDLE or DONE)
//   pl_valid_i/pl_ready_o   preload handshake; pl_addr_i/pl_data_i/pl_last_i
//   dm_we_o/dm_addr_o/
//   dm_wdata_o              data memory write port
//   rf_we_o/rf_addr_o/
//   rf_wdata_o/rf_rdata_i   register file write port and combinational read
//   cpu_reset_o, cpu_done_i core reset (registered) and done flag
//   dump_valid_o/dump_ready_i/dump_idx_o/dump_data_o   register dump stream
//   busy_o, run_done_o      status: not IDLE/DONE, and in DONE
//   timed_out_o             last run was aborted by the timeout
//   cycle_count_o           RUN cycles of the last run (saturates at TIMEOUT)
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 8,
    parameter int unsigned RF_AW   = 3,
    parameter int unsigned CYC_W   = 32,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             go_i,
    input  logic             pl_valid_i,
    output logic             pl_ready_o,
    input  logic [AW-1:0]    pl_addr_i,
    input  logic [DW-1:0]    pl_data_i,
    input  logic             pl_last_i,
    output logic             dm_we_o,
    output logic [AW-1:0]    dm_addr_o,
    output logic [DW-1:0]    dm_wdata_o,
    output logic             rf_we_o,
    output logic [RF_AW-1:0] rf_addr_o,
    output logic [DW-1:0]    rf_wdata_o,
    input  logic [DW-1:0]    rf_rdata_i,
    output logic             cpu_reset_o,
    input  logic             cpu_done_i,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic [RF_AW-1:0] dump_idx_o,
    output logic [DW-1:0]    dump_data_o,
    output logic             busy_o,
    output logic             run_done_o,
    output logic             timed_out_o,
    output logic [CYC_W-1:0] cycle_count_o
`ifdef RUNCTL_PC_TRACE_EN
    ,
    input  logic [AW-1:0]    cpu_pc_i,
    output logic             trace_valid_o,
    output logic [AW-1:0]    trace_pc_o
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StClrDm,
        StClrRf,
        StPreload,
        StRelease,
        StRun,
        StDump,
        StDone
    } state_e;

    localparam logic [AW-1:0]    DmLast   = {AW{1'b1}};
    localparam logic [RF_AW-1:0] RfLast   = {RF_AW{1'b1}};
    localparam logic [CYC_W-1:0] TimeoutC = CYC_W'(TIMEOUT);

    state_e            state_q;
    logic [AW-1:0]     dm_cnt_q;     // clear address in CLR_DM
    logic [RF_AW-1:0]  idx_q;        // register index in CLR_RF and DUMP
    logic [CYC_W-1:0]  cyc_q;
    logic              timed_out_q;
    logic              cpu_reset_q;

    // Saturating increment: the counter parks at TIMEOUT and never wraps.
    logic [CYC_W-1:0]  cyc_inc;
    assign cyc_inc = (cyc_q == TimeoutC) ? cyc_q : cyc_q + CYC_W'(1);

    // -------------------------------------------------------------------------
    // Sequencer state, counters and the registered core reset.
    // Counters wrap to zero on their last step, so each phase starts at 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            dm_cnt_q    <= '0;
            idx_q       <= '0;
            cyc_q       <= '0;
            timed_out_q <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (go_i) begin
                        state_q     <= StClrDm;
                        dm_cnt_q    <= '0;
                        idx_q       <= '0;
                        cyc_q       <= '0;
                        timed_out_q <= 1'b0;
                    end
                end
                StClrDm: begin
                    dm_cnt_q <= dm_cnt_q + AW'(1);
                    if (dm_cnt_q == DmLast) begin
                        state_q <= StClrRf;
                    end
                end
                StClrRf: begin
                    idx_q <= idx_q + RF_AW'(1);
                    if (idx_q == RfLast) begin
                        state_q <= StPreload;
                    end
                end
                StPreload: begin
                    if (pl_valid_i && pl_last_i) begin
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    // Dropping the registered reset here makes it low from the
                    // first RUN cycle onward.
                    state_q     <= StRun;
                    cpu_reset_q <= 1'b0;
                end
                StRun: begin
                    cyc_q <= cyc_inc;
                    // cpu_done takes priority over a coincident timeout.
                    if (cpu_done_i) begin
                        state_q     <= StDump;
                        timed_out_q <= 1'b0;
                        cpu_reset_q <= 1'b1;
                        idx_q       <= '0;
                    end else if (cyc_inc == TimeoutC) begin
                        state_q     <= StDump;
                        timed_out_q <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        idx_q       <= '0;
                    end
                end
                StDump: begin
                    if (dump_ready_i) begin
                        idx_q <= idx_q + RF_AW'(1);
                        if (idx_q == RfLast) begin
                            state_q <= StDone;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cpu_reset_q <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode. Preload writes and dump data are combinational
    // pass-throughs so the host and the register file see no extra latency.
    // -------------------------------------------------------------------------
    always_comb begin
        pl_ready_o   = 1'b0;
        dm_we_o      = 1'b0;
        dm_addr_o    = '0;
        dm_wdata_o   = '0;
        rf_we_o      = 1'b0;
        rf_addr_o    = '0;
        rf_wdata_o   = '0;
        dump_valid_o = 1'b0;
        dump_idx_o   = '0;
        dump_data_o  = '0;
        busy_o       = 1'b1;
        run_done_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
            end
            StDone: begin
                busy_o     = 1'b0;
                run_done_o = 1'b1;
            end
            StClrDm: begin
                dm_we_o   = 1'b1;
                dm_addr_o = dm_cnt_q;
            end
            StClrRf: begin
                rf_we_o   = 1'b1;
                rf_addr_o = idx_q;
            end
            StPreload: begin
                pl_ready_o = 1'b1;
                if (pl_valid_i) begin
                    dm_we_o    = 1'b1;
                    dm_addr_o  = pl_addr_i;
                    dm_wdata_o = pl_data_i;
                end
            end
            StDump: begin
                rf_addr_o    = idx_q;
                dump_valid_o = 1'b1;
                dump_idx_o   = idx_q;
                dump_data_o  = rf_rdata_i;
            end
            default: begin
                // RELEASE and RUN drive only busy.
            end
        endcase
    end

    assign cpu_reset_o   = cpu_reset_q;
    assign timed_out_o   = timed_out_q;
    assign cycle_count_o = cyc_q;

`ifdef RUNCTL_PC_TRACE_EN
    // -------------------------------------------------------------------------
    // PC trace: emit whenever the core PC changes during RUN. The first RUN
    // cycle always emits because there is no meaningful previous PC.
    // -------------------------------------------------------------------------
    logic [AW-1:0] pc_prev_q;
    logic          trace_first_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_prev_q     <= '0;
            trace_first_q <= 1'b0;
        end else begin
            pc_prev_q     <= cpu_pc_i;
            trace_first_q <= (state_q == StRelease);
        end
    end

    assign trace_valid_o = (state_q == StRun) && (trace_first_q || (cpu_pc_i != pc_prev_q));
    assign trace_pc_o    = trace_valid_o ? cpu_pc_i : '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cpu_run_ctrl. The bench owns the data memory and
// register file arrays (written by the DUT's write ports, read combinationally
// for the dump) and plays the core: it loads register values during RUN and
// raises cpu_done on a chosen RUN cycle. Expected memory contents, run length,
// timeout flag and dump stream are derived from the run rules directly.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int RF_AW = 3;
    localparam int CYC_W = 32;
    localparam int TO    = 50;
    localparam int NREG  = 1 << RF_AW;
    localparam int DEPTH = 1 << AW;

    logic             clk;
    logic             reset;
    logic             go;
    logic             pl_valid;
    logic             pl_ready;
    logic [AW-1:0]    pl_addr;
    logic [DW-1:0]    pl_data;
    logic             pl_last;
    logic             dm_we;
    logic [AW-1:0]    dm_addr;
    logic [DW-1:0]    dm_wdata;
    logic             rf_we;
    logic [RF_AW-1:0] rf_addr;
    logic [DW-1:0]    rf_wdata;
    logic [DW-1:0]    rf_rdata;
    logic             cpu_reset;
    logic             cpu_done;
    logic             dump_valid;
    logic             dump_ready;
    logic [RF_AW-1:0] dump_idx;
    logic [DW-1:0]    dump_data;
    logic             busy;
    logic             run_done;
    logic             timed_out;
    logic [CYC_W-1:0] cycle_count;

    logic [DW-1:0] dm_mem  [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] rf_mem  [NREG];
    logic [DW-1:0] rf_exp  [NREG];

    int n_tests = 0;
    int n_fail  = 0;

    assign rf_rdata = rf_mem[rf_addr];

    cpu_run_ctrl #(
        .DW      (DW),
        .AW      (AW),
        .RF_AW   (RF_AW),
        .CYC_W   (CYC_W),
        .TIMEOUT (TO)
    ) u_dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .go_i          (go),
        .pl_valid_i    (pl_valid),
        .pl_ready_o    (pl_ready),
        .pl_addr_i     (pl_addr),
        .pl_data_i     (pl_data),
        .pl_last_i     (pl_last),
        .dm_we_o       (dm_we),
        .dm_addr_o     (dm_addr),
        .dm_wdata_o    (dm_wdata),
        .rf_we_o       (rf_we),
        .rf_addr_o     (rf_addr),
        .rf_wdata_o    (rf_wdata),
        .rf_rdata_i    (rf_rdata),
        .cpu_reset_o   (cpu_reset),
        .cpu_done_i    (cpu_done),
        .dump_valid_o  (dump_valid),
        .dump_ready_i  (dump_ready),
        .dump_idx_o    (dump_idx),
        .dump_data_o   (dump_data),
        .busy_o        (busy),
        .run_done_o    (run_done),
        .timed_out_o   (timed_out),
        .cycle_count_o (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Commit this cycle's memory writes, then advance to just after the edge.
    task automatic step();
        if (dm_we) dm_mem[dm_addr] = dm_wdata;
        if (rf_we) rf_mem[rf_addr] = rf_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic do_abort(input string tag);
        reset = 1'b1;
        cpu_done = 1'b0;
        dump_ready = 1'b0;
        go = 1'b0;
        step();
        reset = 1'b0;
        check_eq({tag, "_flags"},
                 {busy, run_done, dump_valid, cpu_reset, pl_ready, dm_we, rf_we},
                 7'b0001000);
        check_eq({tag, "_count"}, cycle_count, 0);
        check_eq({tag, "_to"}, timed_out, 0);
        step();
        check_eq({tag, "_idle"}, {busy, cpu_reset}, 2'b01);
    endtask

    // done_at: RUN cycle (1-based) on which cpu_done is raised.
    // abort_mode: 0 none, 1 reset in RUN, 2 reset in DUMP.
    task automatic run_one(input int done_at, input int abort_mode, input bit fixed);
        int n, dm_n, rf_n, seq_err, busy_err, pl_err, mem_err, rf_err;
        int exit_k, exp_k, idx, cyc;
        bit exp_to, rdy;
        logic [AW-1:0] pa [$];
        logic [DW-1:0] pd [$];
        int            pg [$];
        logic [11:0]   exp_w;

        for (int i = 0; i < DEPTH; i++) dm_mem[i] = DW'($urandom);
        for (int i = 0; i < NREG; i++) rf_mem[i] = DW'($urandom);

        go = 1'b1;
        step();
        go = 1'b0;
        check_eq("start_count_clr", cycle_count, 0);
        check_eq("start_to_clr", timed_out, 0);

        n = 1; dm_n = 0; rf_n = 0; seq_err = 0; busy_err = 0;
        while (!pl_ready && n < 400) begin
            if (dm_we) begin
                if (dm_addr != AW'(dm_n) || dm_wdata != '0) seq_err++;
                dm_n++;
            end
            if (rf_we) begin
                if (rf_addr != RF_AW'(rf_n)) seq_err++;
                rf_n++;
            end
            if (!busy || !cpu_reset) busy_err++;
            step();
            n++;
        end
        check_eq("pl_ready_cycle", n, 265);
        check_eq("clr_dm_writes", dm_n, DEPTH);
        check_eq("clr_rf_writes", rf_n, NREG);
        check_eq("clr_sequence", seq_err, 0);
        check_eq("clr_busy_reset", busy_err, 0);
        rf_err = 0;
        for (int i = 0; i < NREG; i++) if (rf_mem[i] != '0) rf_err++;
        check_eq("rf_cleared", rf_err, 0);

        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        if (fixed) begin
            pa = '{8'd1, 8'd2, 8'd3, 8'd4};
            pd = '{8'h03, 8'hff, 8'hff, 8'hfb};
            pg = '{0, 0, 0, 2};
        end else begin
            int k;
            k = $urandom_range(1, 10);
            for (int j = 0; j < k; j++) begin
                pa.push_back(AW'($urandom_range(0, 15)));
                pd.push_back(DW'($urandom));
                pg.push_back($urandom_range(0, 2));
            end
        end

        pl_err = 0;
        for (int j = 0; j < pa.size(); j++) begin
            for (int g = 0; g < pg[j]; g++) begin
                pl_valid = 1'b0;
                pl_addr  = AW'($urandom);
                pl_data  = DW'($urandom);
                pl_last  = fixed ? 1'b0 : 1'($urandom);
                #1;
                if ({pl_ready, dm_we} != 2'b10) pl_err++;
                step();
            end
            pl_valid = 1'b1;
            pl_addr  = pa[j];
            pl_data  = pd[j];
            pl_last  = (j == pa.size() - 1);
            #1;
            check_eq("pl_write", {pl_ready, dm_we, dm_addr, dm_wdata}, {2'b11, pa[j], pd[j]});
            exp_mem[pa[j]] = pd[j];
            step();
        end
        pl_valid = 1'b0;
        pl_last  = 1'b0;
        check_eq("pl_gap", pl_err, 0);
        check_eq("release", {cpu_reset, busy, pl_ready, dm_we}, 4'b1100);
        step();
        check_eq("run_cpu_reset", cpu_reset, 0);

        mem_err = 0;
        for (int i = 0; i < DEPTH; i++) if (dm_mem[i] !== exp_mem[i]) mem_err++;
        check_eq("dm_contents", mem_err, 0);

        // Core model: registers take their final values during the run.
        for (int i = 0; i < NREG; i++) begin
            rf_mem[i] = fixed ? DW'(8'h10 + i) : DW'($urandom);
            rf_exp[i] = rf_mem[i];
        end

        exit_k = 0;
        for (int k = 1; k <= TO + 5; k++) begin
            cpu_done = (k == done_at);
            go = 1'($urandom);
            if (abort_mode == 1 && k == 5) begin
                do_abort("abort_run");
                return;
            end
            step();
            if (dump_valid) begin
                exit_k = k;
                break;
            end
        end
        cpu_done = 1'b0;
        go = 1'b0;
        exp_k  = (done_at <= TO) ? done_at : TO;
        exp_to = (done_at > TO);
        check_eq("run_length", exit_k, exp_k);
        check_eq("cycle_count", cycle_count, exp_k);
        check_eq("timed_out", timed_out, exp_to);
        check_eq("dump_cpu_reset", {cpu_reset, busy}, 2'b11);

        idx = 0;
        cyc = 0;
        while (idx < NREG && cyc < 200) begin
            rdy = fixed ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom);
            dump_ready = rdy;
            go = 1'($urandom);
            if (abort_mode == 2 && idx == 3) begin
                do_abort("abort_dump");
                return;
            end
            #1;
            exp_w = {1'b1, RF_AW'(idx), rf_exp[idx]};
            check_eq("dump_word", {dump_valid, dump_idx, dump_data}, exp_w);
            if (rdy) idx++;
            step();
            cyc++;
        end
        dump_ready = 1'b0;
        go = 1'b0;
        check_eq("dump_complete", idx, NREG);
        check_eq("done_flags", {run_done, busy, dump_valid, cpu_reset}, 4'b1001);
        check_eq("done_count", cycle_count, exp_k);
        check_eq("done_to", timed_out, exp_to);
    endtask

    initial begin
        reset = 1'b1;
        go = 1'b0;
        pl_valid = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        pl_last = 1'b0;
        cpu_done = 1'b0;
        dump_ready = 1'b0;
        step();
        step();
        check_eq("reset_flags",
                 {cpu_reset, busy, run_done, pl_ready, dm_we, rf_we, dump_valid, timed_out},
                 8'b1000_0000);
        check_eq("reset_buses", {dm_addr, dm_wdata, rf_addr, dump_idx, dump_data}, 0);
        check_eq("reset_count", cycle_count, 0);
        reset = 1'b0;
        step();
        check_eq("idle_hold", {busy, cpu_reset, run_done}, 3'b010);

        run_one(37, 0, 1'b1);
        run_one(1000, 0, 1'b0);
        run_one(TO, 0, 1'b0);
        run_one(10, 1, 1'b0);
        run_one(20, 2, 1'b0);
        for (int r = 0; r < 4; r++) run_one($urandom_range(1, TO + 10), 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
